exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception/interrupt commit controller in the MEM stage, directly upstream of the CP0 register block. It collects per-instruction exception flags and external interrupt lines, then selects one event by fixed priority. It drives the CP0 commit inputs (cause, PC, delay-slot, eret) and sequences the pipeline flush and fetch redirect to the exception vector or the EPC.

## Interface
- `EXC_VECTOR`, 32'hBFC00380: redirect target for every exception and interrupt.
- `FLUSH_CYCLES`, 2: number of cycles `o_flush` is held (legal range 1–15).
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: MEM-stage instruction valid.
- `i_pc` in 32: PC of the MEM-stage instruction.
- `i_in_delay_slot` in 1: the instruction sits in a branch delay slot.
- `i_exc_flags` in 8: {eret, ades, adel_ld, bp, sys, ov, ri, adel_if}, bit 0 = adel_if.
- `i_int` in 6: raw external interrupt lines.
- `i_status` in 32: CP0 Status (bit 0 IE, bit 1 EXL, bits [15:10] IM).
- `i_epc` in 32: CP0 EPC.
- `i_fetch_ready` in 1: fetch accepts the redirect.
- `o_except_cause` out 5: cause to CP0; `EXC_CAUSE_NOP` when idle.
- `o_current_pc` out 32: faulting PC to CP0.
- `o_is_in_delay_slot` out 1: delay-slot flag to CP0.
- `o_is_eret` out 1: eret commit pulse to CP0.
- `o_int_sync` out 6: synchronised interrupt lines, fed to CP0 `i_int`.
- `o_flush` out 1: kill IF..MEM.
- `o_redirect_valid` out 1: redirect request to fetch.
- `o_redirect_pc` out 32: redirect target.
- `o_busy` out 1: state ≠ IDLE; the hazard unit stalls writeback.

## Operation
- **Interrupt pending:** `IE & ~EXL & |(IM & o_int_sync)`.
- **Event selection** happens only in IDLE with `i_valid = 1`. Priority, highest first:
  - INT (0)
  - AdEL-fetch (4)
  - RI (10)
  - Ov (12)
  - Sys (8)
  - Bp (9)
  - AdEL-load (4)
  - AdES (5)
  - ERET
- The selected instruction does not commit. The MEM stage squashes its writeback while `o_busy` is set or the event is selected.
- **Exceptions** are taken regardless of EXL. CP0 decides EPC update.
- **Interrupts** are taken only when pending.
- **Commit (one-cycle pulses, T+1 after selection):**
  - Exception: `o_except_cause` = code, `o_current_pc` = `i_pc`, `o_is_in_delay_slot` = `i_in_delay_slot`.
  - ERET: `o_is_eret` = 1, cause stays NOP.
- **Redirect target**, latched at selection: `i_epc` for ERET, otherwise `EXC_VECTOR`.
- **FSM states:**
  - IDLE: on event → FLUSH, load a 4-bit counter with `FLUSH_CYCLES` − 1.
  - FLUSH: `o_flush` = 1. Counter decrements each cycle; at 0 → REDIRECT.
  - REDIRECT: `o_redirect_valid` = 1 and `o_redirect_pc` stable until `i_fetch_ready`. On the cycle `i_fetch_ready` = 1 → IDLE.
- Flags and interrupts arriving while not IDLE are ignored. The flushed instructions re-raise them later if still valid.
- **Reset:** all outputs 0, except `o_except_cause` = NOP. FSM → IDLE, counter 0, synchroniser 0. An asynchronous reset mid-FLUSH or mid-REDIRECT aborts immediately, with no pending redirect.

## Timing
- Selection is combinational in cycle T. CP0 commit outputs are registered and valid at T+1 for exactly 1 cycle.
- `o_flush` is high from T+1 through T+`FLUSH_CYCLES`.
- `o_redirect_valid` rises at T+`FLUSH_CYCLES`+1. If `i_fetch_ready` is already high, it falls after 1 cycle.
- `o_busy` is high from T+1 until the cycle after the redirect handshake.
- The earliest new event selection is the cycle after the return to IDLE. Back-to-back exceptions are spaced by at least `FLUSH_CYCLES` + 2 cycles.
- `i_int` becomes visible to the pending logic 2 cycles after the change when the synchroniser is compiled in, 0 cycles when it is not.

## Configuration
- `EXC_INT_SYNC_EN` defined: a 2-flop synchroniser on each `i_int` bit; `o_int_sync` is the second flop output.
- `EXC_INT_SYNC_EN` undefined: `o_int_sync` = `i_int` combinationally and no flops exist. Use this only when the interrupt sources are already in the `clk` domain.

## Structure
- The shared package `exc_pkg` holds:
  - the cause codes `EXC_CAUSE_INT`/`ADEL`/`ADES`/`SYS`/`BP`/`RI`/`OV`/`NOP` (NOP = 5'h1F);
  - the `i_exc_flags` bit-index constants;
  - the FSM state encoding (IDLE = 0, FLUSH = 1, REDIRECT = 2).
- Sub-module `exc_prio_enc`: the combinational priority encoder from {int_pending, flags} to {hit, cause, is_eret}.
- The FSM, counter and synchroniser stay in `exc_ctrl`.

## Test plan
- **Ov exception:** Ov flag, `i_pc` = 0x80001000, not in a delay slot, Status = 0x1000FF00.
  - T+1: cause = 12, `o_current_pc` = 0x80001000 for 1 cycle.
  - `o_flush` high 2 cycles, then redirect to 0xBFC00380.
- **Simultaneous events:** RI and Sys raised together, delay slot = 1, `i_pc` = 0x80000204 → cause = 10, `o_is_in_delay_slot` = 1; Sys ignored.
- **Interrupt vs exception:** Status = 0x1000FF01, `i_int` = 6'b000001, Bp flag set.
  - With `EXC_INT_SYNC_EN`, 2 cycles later → cause = 0 (INT beats Bp).
  - With EXL = 1 → cause = 9.
- **ERET with backpressure:** ERET with `i_epc` = 0x80002000, `i_fetch_ready` held low 5 cycles.
  - `o_is_eret` pulses once.
  - `o_redirect_valid` and `o_redirect_pc` = 0x80002000 stay stable for 5 cycles, then drop the cycle after ready.
- **Events while busy:** Ov raised during FLUSH → ignored; no second commit pulse.
- **Reset mid-operation:** `resetn` low mid-REDIRECT → next edge outputs 0, cause NOP, `o_busy` 0; after release, IDLE with no spurious redirect.

Source files
------------

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - cause codes, exception flag indices and FSM encoding for exc_ctrl
package exc_pkg;

  localparam logic [4:0] EXC_CAUSE_INT  = 5'h00;
  localparam logic [4:0] EXC_CAUSE_ADEL = 5'h04;
  localparam logic [4:0] EXC_CAUSE_ADES = 5'h05;
  localparam logic [4:0] EXC_CAUSE_SYS  = 5'h08;
  localparam logic [4:0] EXC_CAUSE_BP   = 5'h09;
  localparam logic [4:0] EXC_CAUSE_RI   = 5'h0A;
  localparam logic [4:0] EXC_CAUSE_OV   = 5'h0C;
  localparam logic [4:0] EXC_CAUSE_NOP  = 5'h1F;

  localparam int EXC_FLAG_ADEL_IF = 0;
  localparam int EXC_FLAG_RI      = 1;
  localparam int EXC_FLAG_OV      = 2;
  localparam int EXC_FLAG_SYS     = 3;
  localparam int EXC_FLAG_BP      = 4;
  localparam int EXC_FLAG_ADEL_LD = 5;
  localparam int EXC_FLAG_ADES    = 6;
  localparam int EXC_FLAG_ERET    = 7;

  typedef enum logic [1:0] {
    EXC_ST_IDLE     = 2'd0,
    EXC_ST_FLUSH    = 2'd1,
    EXC_ST_REDIRECT = 2'd2
  } exc_state_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - MEM-stage, CP0 and fetch-redirect signals of exc_ctrl
interface exc_ctrl_if;

  logic        i_valid;
  logic [31:0] i_pc;
  logic        i_in_delay_slot;
  logic [7:0]  i_exc_flags;
  logic [5:0]  i_int;
  logic [31:0] i_status;
  logic [31:0] i_epc;
  logic        i_fetch_ready;
  logic [4:0]  o_except_cause;
  logic [31:0] o_current_pc;
  logic        o_is_in_delay_slot;
  logic        o_is_eret;
  logic [5:0]  o_int_sync;
  logic        o_flush;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        o_busy;

  modport master (
    output i_valid, i_pc, i_in_delay_slot, i_exc_flags, i_int, i_status, i_epc, i_fetch_ready,
    input  o_except_cause, o_current_pc, o_is_in_delay_slot, o_is_eret, o_int_sync,
    input  o_flush, o_redirect_valid, o_redirect_pc, o_busy
  );

  modport slave (
    input  i_valid, i_pc, i_in_delay_slot, i_exc_flags, i_int, i_status, i_epc, i_fetch_ready,
    output o_except_cause, o_current_pc, o_is_in_delay_slot, o_is_eret, o_int_sync,
    output o_flush, o_redirect_valid, o_redirect_pc, o_busy
  );

endinterface

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - fixed-priority selection of one event from interrupt and exception flags
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       i_int_pending,
  input  logic [7:0] i_flags,
  output logic       o_hit,
  output logic [4:0] o_cause,
  output logic       o_is_eret
);

  // ERET is a hit with no cause code: CP0 sees only the eret pulse.
  always_comb begin
    o_hit     = 1'b1;
    o_cause   = EXC_CAUSE_NOP;
    o_is_eret = 1'b0;
    if (i_int_pending)                  o_cause = EXC_CAUSE_INT;
    else if (i_flags[EXC_FLAG_ADEL_IF]) o_cause = EXC_CAUSE_ADEL;
    else if (i_flags[EXC_FLAG_RI])      o_cause = EXC_CAUSE_RI;
    else if (i_flags[EXC_FLAG_OV])      o_cause = EXC_CAUSE_OV;
    else if (i_flags[EXC_FLAG_SYS])     o_cause = EXC_CAUSE_SYS;
    else if (i_flags[EXC_FLAG_BP])      o_cause = EXC_CAUSE_BP;
    else if (i_flags[EXC_FLAG_ADEL_LD]) o_cause = EXC_CAUSE_ADEL;
    else if (i_flags[EXC_FLAG_ADES])    o_cause = EXC_CAUSE_ADES;
    else if (i_flags[EXC_FLAG_ERET])    o_is_eret = 1'b1;
    else                                o_hit = 1'b0;
  end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - MEM-stage exception/interrupt commit, flush and redirect sequencer
// Optional EXC_INT_SYNC_EN: 2-flop synchroniser on the external interrupt lines.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  exc_ctrl_if.slave   bus
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  exc_state_t  r_state;
  exc_state_t  w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [5:0]  w_int_sync;
  logic        w_int_pending;
  logic        w_hit;
  logic [4:0]  w_cause;
  logic        w_is_eret;
  logic        w_take;
  logic        w_flush;
  logic        w_redirect_valid;
  logic [4:0]  r_except_cause;
  logic [31:0] r_current_pc;
  logic        r_is_in_delay_slot;
  logic        r_is_eret;
  logic [31:0] r_redirect_pc;
  logic        w_unused;

`ifdef EXC_INT_SYNC_EN
  logic [5:0] r_int_meta;
  logic [5:0] r_int_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_int_meta <= '0;
      r_int_sync <= '0;
    end else begin
      r_int_meta <= bus.i_int;
      r_int_sync <= r_int_meta;
    end
  end

  assign w_int_sync = r_int_sync;
`else
  assign w_int_sync = bus.i_int;
`endif

  assign w_int_pending = bus.i_status[0] & ~bus.i_status[1]
                       & (|(bus.i_status[15:10] & w_int_sync));
  assign w_unused      = &{1'b0, bus.i_status[31:16], bus.i_status[9:2]};

  exc_prio_enc u_prio_enc (
    .i_int_pending (w_int_pending),
    .i_flags       (bus.i_exc_flags),
    .o_hit         (w_hit),
    .o_cause       (w_cause),
    .o_is_eret     (w_is_eret)
  );

  // Anything raised outside IDLE is dropped; the flushed instruction re-raises it.
  assign w_take = (r_state == EXC_ST_IDLE) & bus.i_valid & w_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= EXC_ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_flush          = 1'b0;
    w_redirect_valid = 1'b0;
    case (r_state)
      EXC_ST_IDLE: begin
        if (w_take) begin
          w_state_nxt = EXC_ST_FLUSH;
          w_cnt_nxt   = FLUSH_LOAD;
        end
      end
      EXC_ST_FLUSH: begin
        w_flush = 1'b1;
        if (r_cnt == 4'd0) w_state_nxt = EXC_ST_REDIRECT;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      EXC_ST_REDIRECT: begin
        w_redirect_valid = 1'b1;
        if (bus.i_fetch_ready) w_state_nxt = EXC_ST_IDLE;
      end
      default: w_state_nxt = EXC_ST_IDLE;
    endcase
  end

  // CP0 commit strobes: one cycle after selection, idle values otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_except_cause     <= EXC_CAUSE_NOP;
      r_current_pc       <= '0;
      r_is_in_delay_slot <= 1'b0;
      r_is_eret          <= 1'b0;
    end else begin
      r_except_cause     <= (w_take & ~w_is_eret) ? w_cause : EXC_CAUSE_NOP;
      r_current_pc       <= (w_take & ~w_is_eret) ? bus.i_pc : '0;
      r_is_in_delay_slot <= w_take & ~w_is_eret & bus.i_in_delay_slot;
      r_is_eret          <= w_take & w_is_eret;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_redirect_pc <= '0;
    end else if (w_take) begin
      r_redirect_pc <= w_is_eret ? bus.i_epc : EXC_VECTOR;
    end
  end

  assign bus.o_except_cause     = r_except_cause;
  assign bus.o_current_pc       = r_current_pc;
  assign bus.o_is_in_delay_slot = r_is_in_delay_slot;
  assign bus.o_is_eret          = r_is_eret;
  assign bus.o_int_sync         = w_int_sync;
  assign bus.o_flush            = w_flush;
  assign bus.o_redirect_valid   = w_redirect_valid;
  assign bus.o_redirect_pc      = r_redirect_pc;
  assign bus.o_busy             = (r_state != EXC_ST_IDLE);

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed and randomized self-checking bench for exc_ctrl
module tb_exc_ctrl;

  localparam int          FC  = 2;
  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam logic [4:0]  NOP = 5'h1F;
`ifdef EXC_INT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  // cause code for each flag bit; flag bit order is also the priority order
  localparam logic [4:0] CAUSE_OF_BIT [8] = '{5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05, 5'h1F};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  exc_ctrl_if bus();

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic void model(input logic [7:0] flags, input logic [31:0] st, input logic [5:0] irq,
                                output bit hit, output logic [4:0] cause, output bit eret);
    hit   = 1'b0;
    cause = NOP;
    eret  = 1'b0;
    if (st[0] && !st[1] && ((st[15:10] & irq) != 6'd0)) begin
      hit   = 1'b1;
      cause = 5'h00;
      return;
    end
    for (int b = 0; b < 8; b++) begin
      if (flags[b]) begin
        hit   = 1'b1;
        cause = CAUSE_OF_BIT[b];
        eret  = (b == 7);
        return;
      end
    end
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cause"}, 32'(bus.o_except_cause), 32'(NOP));
    chk({tag, "_pc"}, bus.o_current_pc, 32'd0);
    chk({tag, "_ds"}, 32'(bus.o_is_in_delay_slot), 32'd0);
    chk({tag, "_eret"}, 32'(bus.o_is_eret), 32'd0);
    chk({tag, "_flush"}, 32'(bus.o_flush), 32'd0);
    chk({tag, "_rv"}, 32'(bus.o_redirect_valid), 32'd0);
    chk({tag, "_rpc"}, bus.o_redirect_pc, 32'd0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
  endtask

  task automatic run_event(input logic [7:0] flags, input logic [31:0] pc, input bit ds,
                           input logic [31:0] st, input logic [5:0] irq, input logic [31:0] epc,
                           input int delay, input bit abort);
    bit          hit;
    bit          eret;
    logic [4:0]  cause;
    logic [31:0] rpc;

    tick();
    bus.i_valid = 1'b0;  bus.i_exc_flags = 8'h00;  bus.i_fetch_ready = 1'b0;
    bus.i_status = st;   bus.i_int = irq;          bus.i_epc = epc;
    repeat (SYNC_LAT + 1) tick();
    sample();
    chk("int_sync", 32'(bus.o_int_sync), 32'(irq));
    model(flags, st, irq, hit, cause, eret);
    rpc = eret ? epc : VEC;

    tick();
    bus.i_valid = 1'b1;  bus.i_exc_flags = flags;  bus.i_pc = pc;  bus.i_in_delay_slot = ds;
    sample();
    chk("idle_busy", 32'(bus.o_busy), 32'd0);
    chk("idle_flush", 32'(bus.o_flush), 32'd0);
    if (!hit) begin
      tick();
      bus.i_valid = 1'b0;  bus.i_exc_flags = 8'h00;
      sample();
      chk("nohit_busy", 32'(bus.o_busy), 32'd0);
      chk("nohit_cause", 32'(bus.o_except_cause), 32'(NOP));
      chk("nohit_eret", 32'(bus.o_is_eret), 32'd0);
      return;
    end

    // T+1: commit pulse; keep raising flags to confirm they are ignored while busy
    tick();
    bus.i_exc_flags = 8'h04 | 8'($urandom);  bus.i_pc = $urandom;
    sample();
    chk("commit_cause", 32'(bus.o_except_cause), 32'(cause));
    chk("commit_eret", 32'(bus.o_is_eret), 32'(eret));
    if (!eret) begin
      chk("commit_pc", bus.o_current_pc, pc);
      chk("commit_ds", 32'(bus.o_is_in_delay_slot), 32'(ds));
    end
    chk("flush_t1", 32'(bus.o_flush), 32'd1);
    chk("busy_t1", 32'(bus.o_busy), 32'd1);
    chk("rv_t1", 32'(bus.o_redirect_valid), 32'd0);
    for (int j = 2; j <= FC; j++) begin
      tick();
      sample();
      chk("flush_tj", 32'(bus.o_flush), 32'd1);
      chk("pulse_cause", 32'(bus.o_except_cause), 32'(NOP));
      chk("pulse_eret", 32'(bus.o_is_eret), 32'd0);
    end

    if (abort) begin
      tick();
      bus.i_valid = 1'b0;  bus.i_exc_flags = 8'h00;
      sample();
      chk("abort_rv", 32'(bus.o_redirect_valid), 32'd1);
      tick();
      resetn = 1'b0;
      #1;
      chk_reset_outputs("abort_async");
      tick();
      sample();
      chk_reset_outputs("abort_held");
      tick();
      resetn = 1'b1;
      repeat (3) begin
        tick();
        sample();
        chk("post_rst_rv", 32'(bus.o_redirect_valid), 32'd0);
        chk("post_rst_busy", 32'(bus.o_busy), 32'd0);
        chk("post_rst_flush", 32'(bus.o_flush), 32'd0);
      end
      return;
    end

    for (int k = 0; k <= delay; k++) begin
      tick();
      if (k == 0) begin
        bus.i_valid = 1'b0;  bus.i_exc_flags = 8'h00;
      end
      bus.i_fetch_ready = (k == delay);
      sample();
      chk("rv_high", 32'(bus.o_redirect_valid), 32'd1);
      chk("rv_pc", bus.o_redirect_pc, rpc);
      chk("rv_flush", 32'(bus.o_flush), 32'd0);
      chk("rv_busy", 32'(bus.o_busy), 32'd1);
    end
    tick();
    bus.i_fetch_ready = 1'b0;
    sample();
    chk("done_rv", 32'(bus.o_redirect_valid), 32'd0);
    chk("done_busy", 32'(bus.o_busy), 32'd0);
    chk("done_cause", 32'(bus.o_except_cause), 32'(NOP));
  endtask

  initial begin
    logic [7:0] rflags;
    bus.i_valid = 1'b0;  bus.i_pc = '0;  bus.i_in_delay_slot = 1'b0;  bus.i_exc_flags = '0;
    bus.i_int = '0;      bus.i_status = '0;  bus.i_epc = '0;  bus.i_fetch_ready = 1'b0;
    repeat (2) @(posedge clk);
    sample();
    chk_reset_outputs("reset");
    chk("reset_int_sync", 32'(bus.o_int_sync), 32'd0);
    tick();
    resetn = 1'b1;

    run_event(8'h04, 32'h80001000, 1'b0, 32'h1000FF00, 6'd0, 32'd0, 0, 1'b0);
    run_event(8'h0A, 32'h80000204, 1'b1, 32'h1000FF00, 6'd0, 32'd0, 1, 1'b0);
    run_event(8'h10, 32'h80000300, 1'b0, 32'h1000FF01, 6'b000001, 32'd0, 0, 1'b0);
    run_event(8'h10, 32'h80000300, 1'b0, 32'h1000FF03, 6'b000001, 32'd0, 0, 1'b0);
    run_event(8'h80, 32'h80000400, 1'b0, 32'h1000FF00, 6'd0, 32'h80002000, 5, 1'b0);
    run_event(8'h00, 32'h80000500, 1'b0, 32'h10000001, 6'b111111, 32'd0, 0, 1'b0);
    run_event(8'h60, 32'h80000600, 1'b1, 32'h1000FF00, 6'd0, 32'd0, 2, 1'b0);
    run_event(8'h04, 32'h80000700, 1'b0, 32'h1000FF00, 6'd0, 32'd0, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      rflags = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) rflags = rflags | 8'($urandom);
      run_event(rflags, $urandom, 1'($urandom), {16'h1000, 6'($urandom), 8'h00, 2'($urandom)},
                6'($urandom), $urandom & 32'hFFFFFFFC, int'($urandom_range(0, 4)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
